// File: rtl/display_arbiter_if.sv
// Requester-side display bus of the display arbiter: requests, per-requester
// segment/LED payloads, and the registered grant and pin outputs.
interface display_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_hex30;
  logic [16*N_REQ-1:0] req_hex54;
  logic [10*N_REQ-1:0] req_leds;
  logic [N_REQ-1:0]    grant;
  logic                locked;
  logic [31:0]         hex30_export;
  logic [15:0]         hex54_export;
  logic [9:0]          leds_export;

  modport master (
    output req, req_hex30, req_hex54, req_leds,
    input  grant, locked, hex30_export, hex54_export, leds_export
  );

  modport slave (
    input  req, req_hex30, req_hex54, req_leds,
    output grant, locked, hex30_export, hex54_export, leds_export
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin owner of the 7-segment digits and LEDs, with a minimum hold time,
// and debounced push keys for manual lock (KEY0), advance (KEY1) and clear (KEY3).
module display_arbiter #(
  parameter int unsigned N_REQ           = 2,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [3:0]       keys_n,
  display_arbiter_if.slave bus
);
  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1, sync2, db;
  logic [DW-1:0] db_cnt [4];
  logic [3:0]    press_c;

  logic [1:0]    state, state_n;
  logic [OW-1:0] owner, owner_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [OW-1:0] nxt_any, nxt_oth;
  logic          any_req, oth_req;

  // Press = the debounced level is about to fall this cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      press_c[i] = db[i] & ~sync2[i] & (db_cnt[i] == DB_MAX);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      db    <= 4'hF;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= keys_n;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Round-robin scan from owner+1; the owner itself is considered last (any) or never (oth).
  always_comb begin
    logic [OW-1:0] idx;
    idx     = '0;
    nxt_any = owner;
    nxt_oth = owner;
    any_req = 1'b0;
    oth_req = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = OW'((32'(owner) + k) % N_REQ);
      if (bus.req[idx] && !any_req) begin
        nxt_any = idx;
        any_req = 1'b1;
      end
      if ((k < N_REQ) && bus.req[idx] && !oth_req) begin
        nxt_oth = idx;
        oth_req = 1'b1;
      end
    end
  end

  always_comb begin
    logic [HW-1:0] hold_inc;
    state_n  = state;
    owner_n  = owner;
    hold_n   = hold_cnt;
    hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);
    if (press_c[3]) begin
      state_n = S_IDLE;
      hold_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (press_c[0]) begin
            state_n = S_LOCKED;
            owner_n = '0;
          end else if (!(|press_c[2:1]) && any_req) begin
            state_n = S_GRANT;
            owner_n = nxt_any;
            hold_n  = '0;
          end
        end
        S_GRANT: begin
          if (press_c[0]) begin
            state_n = S_LOCKED;
            hold_n  = '0;
          end else if (|press_c[2:1]) begin
            hold_n = hold_inc;
          end else if (!bus.req[owner]) begin
            hold_n = '0;
            if (oth_req) owner_n = nxt_oth;
            else         state_n = S_IDLE;
          end else if ((hold_cnt == HOLD_MAX) && oth_req) begin
            owner_n = nxt_oth;
            hold_n  = '0;
          end else begin
            hold_n = hold_inc;
          end
        end
        S_LOCKED: begin
          if (press_c[0]) begin
            state_n = S_GRANT;
            hold_n  = '0;
          end else if (press_c[1]) begin
            owner_n = (owner == LAST_IDX) ? '0 : owner + OW'(1);
          end
        end
        default: begin
          state_n = S_IDLE;
          hold_n  = '0;
        end
      endcase
    end
  end

  // Outputs follow the next-state owner so grant and data change together.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state            <= S_IDLE;
      owner            <= '0;
      hold_cnt         <= '0;
      bus.grant        <= '0;
      bus.locked       <= 1'b0;
      bus.hex30_export <= 32'h7F7F7F7F;
      bus.hex54_export <= 16'h7F7F;
      bus.leds_export  <= 10'h0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      hold_cnt   <= hold_n;
      bus.locked <= (state_n == S_LOCKED);
      if (state_n == S_IDLE) begin
        bus.grant        <= '0;
        bus.hex30_export <= 32'h7F7F7F7F;
        bus.hex54_export <= 16'h7F7F;
        bus.leds_export  <= 10'h0;
      end else begin
        bus.grant        <= N_REQ'(1) << owner_n;
        bus.hex30_export <= bus.req_hex30[32*owner_n +: 32];
        bus.hex54_export <= bus.req_hex54[16*owner_n +: 16];
        bus.leds_export  <= bus.req_leds[10*owner_n +: 10];
      end
    end
  end
endmodule
